// File: rtl/vga_score_num.sv
// vga_score_num: renders a 16-bit unsigned score as five decimal digit tiles
// in the background tile RAM. A free-running double-dabble converter
// refreshes the displayed digits every 18 cycles. A sequencer streams one
// tile address/data pair per clock, sweeping the five digit positions.
//
// Optional build macro: LEADING_ZERO_BLANK_EN. When defined, digits left of
// the most-significant nonzero digit are emitted with the enable bit clear.
// The units digit is always enabled.
//
// Ports:
//   clk    in   1   system clock
//   reset  in   1   asynchronous, active-high reset
//   en     in   1   1 = draw digits, 0 = draw blank (all-zero) tiles
//   num    in  16   unsigned score value
//   addr   out 16   tile RAM address
//   data   out 16   tile RAM word {7'b0, enable, yflip, xflip, row[2:0], col[2:0]}
module vga_score_num #(
    parameter int unsigned TILE_COLS = 40,
    parameter int unsigned POS_ROW   = 0,
    parameter int unsigned POS_COL   = 30,
    parameter int unsigned DIGIT_ROW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] num,
    output logic [15:0] addr,
    output logic [15:0] data
);

    localparam logic [15:0] BASE_ADDR = 16'(POS_ROW * TILE_COLS + POS_COL);
    localparam logic [2:0]  GLYPH_ROW = 3'(DIGIT_ROW);

    typedef enum logic [1:0] {
        StLoad,
        StShift,
        StCommit
    } conv_state_e;

    conv_state_e conv_state_q, conv_state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [19:0] bcd_adj;
    // Displayed digits: [19:16] is ten-thousands, [3:0] is units.
    logic [19:0] disp_q, disp_d;

    logic [2:0]  slot_q, slot_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;

    logic [3:0]  cur_digit;
    logic        cur_shown;
    logic [4:0]  shown;

    // Converter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_state_q <= StLoad;
            bit_cnt_q    <= 4'd0;
            bin_q        <= 16'd0;
            bcd_q        <= 20'd0;
            disp_q       <= 20'd0;
        end else begin
            conv_state_q <= conv_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            disp_q       <= disp_d;
        end
    end

    // Add 3 to every nibble >= 5 so the following shift carries decimally.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter next state
    always_comb begin
        conv_state_d = conv_state_q;
        bit_cnt_d    = bit_cnt_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        disp_d       = disp_q;
        unique case (conv_state_q)
            StLoad: begin
                bin_d        = num;
                bcd_d        = 20'd0;
                bit_cnt_d    = 4'd0;
                conv_state_d = StShift;
            end
            StShift: begin
                bcd_d     = {bcd_adj[18:0], bin_q[15]};
                bin_d     = {bin_q[14:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    conv_state_d = StCommit;
                end
            end
            StCommit: begin
                disp_d       = bcd_q;
                conv_state_d = StLoad;
            end
            default: begin
                conv_state_d = StLoad;
            end
        endcase
    end

    // shown[k]: digit k is at or right of the most-significant nonzero digit.
    always_comb begin
        shown[0] = (disp_q[19:16] != 4'd0);
        shown[1] = shown[0] | (disp_q[15:12] != 4'd0);
        shown[2] = shown[1] | (disp_q[11:8] != 4'd0);
        shown[3] = shown[2] | (disp_q[7:4] != 4'd0);
        shown[4] = 1'b1;
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_shown = 1'b1;
        unique case (slot_q)
            3'd0:    begin cur_digit = disp_q[19:16]; cur_shown = shown[0]; end
            3'd1:    begin cur_digit = disp_q[15:12]; cur_shown = shown[1]; end
            3'd2:    begin cur_digit = disp_q[11:8];  cur_shown = shown[2]; end
            3'd3:    begin cur_digit = disp_q[7:4];   cur_shown = shown[3]; end
            3'd4:    begin cur_digit = disp_q[3:0];   cur_shown = shown[4]; end
            default: begin cur_digit = 4'd0;          cur_shown = 1'b1;     end
        endcase
    end

    // Sequencer next state and tile word
    always_comb begin
        logic       tile_en;
        logic [2:0] tile_row;
        slot_d   = (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
        addr_d   = BASE_ADDR + {13'd0, slot_q};
        tile_row = GLYPH_ROW + {2'd0, cur_digit[3]};
`ifdef LEADING_ZERO_BLANK_EN
        tile_en  = cur_shown;
`else
        tile_en  = 1'b1;
`endif
        data_d   = 16'd0;
        if (en) begin
            data_d = {7'd0, tile_en, 2'b00, tile_row, cur_digit[2:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= 3'd0;
            addr_q <= BASE_ADDR;
            data_q <= 16'd0;
        end else begin
            slot_q <= slot_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: tb/tb_vga_score_num.sv
// Self-checking bench for vga_score_num. A cycle-level reference model derives
// the displayed value from the 18-cycle conversion period and computes each
// expected tile word with decimal arithmetic.
module tb_vga_score_num;

    localparam int TILE_COLS = 40;
    localparam int POS_ROW   = 0;
    localparam int POS_COL   = 30;
    localparam int DIGIT_ROW = 3;
    localparam int BASE      = POS_ROW * TILE_COLS + POS_COL;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] num;
    logic [15:0] addr;
    logic [15:0] data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int n_edge;    // clock edges since reset release
    int slot_m;    // digit position the next output refers to
    int snap_m;    // value captured at the start of a conversion
    int disp_m;    // value currently displayed

    vga_score_num #(
        .TILE_COLS(TILE_COLS),
        .POS_ROW  (POS_ROW),
        .POS_COL  (POS_COL),
        .DIGIT_ROW(DIGIT_ROW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .num  (num),
        .addr (addr),
        .data (data)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        case (k)
            0: return 10000;
            1: return 1000;
            2: return 100;
            3: return 10;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int v, input int k, input logic e);
        int p;
        int d;
        int shown;
        p     = pow10(k);
        d     = (v / p) % 10;
        shown = 1;
`ifdef LEADING_ZERO_BLANK_EN
        shown = (k == 4 || v >= p) ? 1 : 0;
`endif
        if (!e) return 16'h0000;
        return 16'((shown << 8) | ((DIGIT_ROW + d / 8) << 3) | (d % 8));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        n_edge = 0;
        slot_m = 0;
        snap_m = 0;
        disp_m = 0;
    endtask

    // Advance the given number of clocks, checking outputs after each edge.
    task automatic run(input int cycles);
        logic [15:0] ea;
        logic [15:0] ed;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            n_edge++;
            ea = 16'(BASE + slot_m);
            ed = exp_word(disp_m, slot_m, en);
            slot_m = (slot_m + 1) % 5;
            if (n_edge % 18 == 1) snap_m = int'(num);
            if (n_edge % 18 == 0) disp_m = snap_m;
            #1;
            check("addr", addr, ea);
            check("data", data, ed);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        num   = 16'd0;
        model_reset();
        #12;
        check("reset_addr", addr, 16'(BASE));
        check("reset_data", data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        run(40);

        num = 16'd1234;
        run(45);
        num = 16'd65535;
        run(45);
        num = 16'd98;
        run(45);

        en  = 1'b0;
        num = 16'd1234;
        run(45);
        en  = 1'b1;
        run(10);

        // Change mid-conversion: old value commits first, new one follows.
        num = 16'd100;
        run(40);
        run(5);
        num = 16'd200;
        run(40);

        // Asynchronous reset mid-stream
        #2;
        reset = 1'b1;
        #1;
        check("async_addr", addr, 16'(BASE));
        check("async_data", data, 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run(20);

        for (int i = 0; i < 8; i++) begin
            num = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) num = 16'($urandom_range(0, 999));
            en  = 1'($urandom_range(0, 3) != 0);
            run(40);
        end

        en  = 1'b1;
        num = 16'd42;
        run(45);
        num = 16'd0;
        run(45);
        num = 16'd10000;
        run(45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_score_num.md
Name: vga_score_num

Overview:
- Renders a 16-bit unsigned score as five decimal digit tiles in the background tile RAM.
- Converts the binary value to BCD with a sequential double-dabble engine.
- Streams one tile-RAM address/data pair per clock, cycling continuously over the five digit positions.
- Sits beside the game engine, which muxes addr/data onto the background RAM write port during its score slot.

Parameters:
- TILE_COLS, 40, tiles per screen row (address stride).
- POS_ROW, 0, screen tile row of the score field.
- POS_COL, 30, screen tile column of the most-significant digit.
- DIGIT_ROW, 3, sprite-sheet row holding digit glyphs 0-7; glyphs 8-9 sit on DIGIT_ROW+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = draw digits, 0 = draw blank tiles.
- num  in  16  unsigned score value.
- addr  out  16  tile RAM address.
- data  out  16  tile RAM word.

Behaviour:
- One clock; reset is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values:
  - slot counter = 0.
  - addr = POS_ROW*TILE_COLS+POS_COL.
  - data = 0.
  - Displayed BCD digits = 0.
  - Converter in LOAD state.
- Tile word format:
  - [2:0] sheet column.
  - [5:3] sheet row.
  - [6] x-flip = 0.
  - [7] y-flip = 0.
  - [8] enable.
  - [15:9] = 0.
- Digit d maps to sheet column d mod 8 and sheet row DIGIT_ROW + d/8.
- Sequencer:
  - A 3-bit slot counter counts 0..4 and wraps to 0, advancing every clock after reset release.
  - Slot 0 is the ten-thousands digit; slot 4 is the units digit.
  - addr and data are registered. In the clock after the counter holds k:
    - addr = POS_ROW*TILE_COLS + POS_COL + k.
    - data = tile word of displayed digit k, with enable = en.
  - en = 0 keeps addr sequencing but forces data = 0.
- Converter FSM, free-running:
  - LOAD (1 cycle): snapshot num into the shift register; clear the 20-bit BCD accumulator.
  - SHIFT (16 cycles): on each cycle, add 3 to every BCD nibble >= 5, then shift the {BCD, binary} register left by 1.
  - COMMIT (1 cycle): copy the five nibbles into the displayed-digit registers; return to LOAD.
  - Period is 18 cycles.
  - Changes to num during SHIFT are ignored until the next LOAD.
  - Displayed value reflects a new num within 36 cycles.
- Displayed digits only change at COMMIT, so a five-tile sweep may straddle an update; the next full sweep is consistent.
- Range: 0..65535. No overflow case exists; five digits always suffice.
- Reset mid-conversion aborts the conversion; the first valid display follows 18 cycles after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits left of the most-significant nonzero digit emit data with enable = 0, same row/column fields.
  - The units digit is always enabled, so num = 0 shows a single "0".
- When undefined: all five digits are always shown, zero padded.

Test Plan:
- Reset held, then released with en=1, num=0 -> addr sequence 30,31,32,33,34,30,... Every data = 0x118.
- num=1234, wait 40 cycles -> one sweep gives data 0x118, 0x119, 0x11A, 0x11B, 0x11C at addr 30..34.
- num=65535 -> data 0x11E, 0x11D, 0x11D, 0x11B, 0x11D. num=98 -> slots 3 and 4 = 0x121, 0x120.
- en=0 with num=1234 -> addr still cycles 30..34; data = 0x0000 each slot. Re-asserting en restores digit words on the next clock.
- num changes 100 -> 200 mid-SHIFT -> display shows 100 after that COMMIT, then 200 within 36 cycles. Asserting reset mid-stream -> addr = 30 and data = 0 immediately.
- With LEADING_ZERO_BLANK_EN defined and num=42 -> slots 0-2 = 0x018 (enable clear), slot 3 = 0x11C, slot 4 = 0x11A. With num=0, slot 4 = 0x118.
